// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED pattern generator (off/on/blink/breathe)
module led_pattern_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 24,
  parameter int PWM_W    = 8
) (
  input  logic                  pin3_clk_16mhz,
  input  logic                  pin4_rst_n,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led,
  output logic                  tick_o
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [PWM_W-1:0]    duty_q [CHANNELS];
  logic [PWM_W-1:0]    duty_d [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic                tick_q;
  logic                tick;

  always_comb begin
    tick      = &presc_q;
    presc_d   = presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    phase_d   = phase_q;
    dir_d     = dir_q;
    led_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_d[i] = duty_q[i];
      // Pattern state runs in every mode so a mode switch resumes mid-pattern.
      if (tick) begin
        phase_d[i] = ~phase_q[i];
        if (dir_q[i]) begin
          if (&duty_q[i]) begin
            dir_d[i]  = 1'b0;
            duty_d[i] = duty_q[i] - 1'b1;
          end else begin
            duty_d[i] = duty_q[i] + 1'b1;
          end
        end else begin
          if (duty_q[i] == '0) begin
            dir_d[i]  = 1'b1;
            duty_d[i] = {{(PWM_W-1){1'b0}}, 1'b1};
          end else begin
            duty_d[i] = duty_q[i] - 1'b1;
          end
        end
      end
      case (mode[2*i +: 2])
        MODE_OFF:     led_d[i] = 1'b0;
        MODE_ON:      led_d[i] = 1'b1;
        MODE_BLINK:   led_d[i] = phase_q[i];
        MODE_BREATHE: led_d[i] = (pwm_cnt_q < duty_q[i]);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pin3_clk_16mhz or negedge pin4_rst_n) begin
    if (!pin4_rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
      dir_q     <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= i[0];
        duty_q[i]  <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      tick_q    <= tick;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led    = led_q;
  assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen (DIV_W=4, PWM_W=3)
module tb_led_pattern_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mode  = 8'h00;
  logic [3:0] led;
  logic       tick_o;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb_q [$];
  logic [3:0] m_presc;
  logic [2:0] m_pwm;
  logic [3:0] m_phase;
  logic [3:0] m_dir;
  logic [2:0] m_duty [4];
  int ecnt, first_tick, tick_cnt, acc, win_ch;
  bit win_en;

  led_pattern_gen #(.CHANNELS(4), .DIV_W(4), .PWM_W(3)) dut (
    .pin3_clk_16mhz(clk),
    .pin4_rst_n    (rst_n),
    .mode          (mode),
    .led           (led),
    .tick_o        (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ecnt, got, exp);
    end
  endtask

  function automatic int tri_duty(input int k);
    int r;
    r = k % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  task automatic model_reset();
    m_presc = '0;
    m_pwm   = '0;
    m_phase = 4'b1010;
    m_dir   = 4'hF;
    for (int i = 0; i < 4; i++) m_duty[i] = '0;
    ecnt = 0; first_tick = 0; tick_cnt = 0; acc = 0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, predict, compare just after posedge.
  task automatic step(input logic [7:0] m);
    logic [3:0] l;
    logic [4:0] exp;
    mode = m;
    for (int i = 0; i < 4; i++) begin
      case (m[2*i +: 2])
        2'b00:   l[i] = 1'b0;
        2'b01:   l[i] = 1'b1;
        2'b10:   l[i] = m_phase[i];
        default: l[i] = (m_pwm < m_duty[i]);
      endcase
    end
    sb_q.push_back({(m_presc == 4'hF), l});
    if (m_presc == 4'hF) begin
      m_phase = ~m_phase;
      for (int i = 0; i < 4; i++) begin
        if (m_dir[i]) begin
          if (m_duty[i] == 3'd7) begin m_dir[i] = 1'b0; m_duty[i] = 3'd6; end
          else m_duty[i] = m_duty[i] + 3'd1;
        end else begin
          if (m_duty[i] == 3'd0) begin m_dir[i] = 1'b1; m_duty[i] = 3'd1; end
          else m_duty[i] = m_duty[i] - 3'd1;
        end
      end
    end
    m_presc = m_presc + 4'd1;
    m_pwm   = m_pwm + 3'd1;
    @(posedge clk);
    #1;
    ecnt++;
    exp = sb_q.pop_front();
    check("sb", {tick_o, led}, exp);
    if (tick_o) tick_cnt++;
    if (tick_o && first_tick == 0) first_tick = ecnt;
    if (ecnt % 16 == 1) acc = 0;
    if (win_en) begin
      if (ecnt % 16 >= 2 && ecnt % 16 <= 9) acc += int'(led[win_ch]);
      if (ecnt % 16 == 9) check("pwm_win", acc, tri_duty(ecnt / 16));
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int n, input logic [7:0] m);
    while (ecnt < n) step(m);
  endtask

  task automatic reset_pulse(input bit chk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("async_led", led, 4'h0);
      check("async_tick", tick_o, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    if (chk) begin
      check("held_led", led, 4'h0);
      check("held_tick", tick_o, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    win_en = 0; win_ch = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_led", led, 4'h0);
    check("rst_tick", tick_o, 1'b0);
    reset_pulse(0);

    // Asynchronous reset mid-pattern with all LEDs lit
    run_to(37, 8'hFF);
    run_to(39, 8'h55);
    check("pre_rst_led", led, 4'hF);
    reset_pulse(1);
    run_to(20, 8'hFF);
    check("first_tick", first_tick, 16);

    // Static modes
    reset_pulse(0);
    run_to(2, 8'h11);
    check("static_on", led, 4'b0101);
    run_to(40, 8'h11);
    check("static_ticks", led, 4'b0101);
    step(8'h00);
    check("static_off", led, 4'b0000);

    // Blink
    reset_pulse(0);
    run_to(2, 8'hAA);
    check("blink_init", led, 4'b1010);
    run_to(16, 8'hAA);
    check("blink_pre_tick", led, 4'b1010);
    check("blink_tick16", tick_o, 1'b1);
    run_to(17, 8'hAA);
    check("blink_t1", led, 4'b0101);
    run_to(33, 8'hAA);
    check("blink_t2", led, 4'b1010);
    run_to(49, 8'hAA);
    check("blink_t3", led, 4'b0101);
    run_to(64, 8'hAA);
    check("tick_count", tick_cnt, 4);

    // Breathe ramp over a full triangle
    reset_pulse(0);
    win_en = 1; win_ch = 0;
    run_to(240, 8'hFF);
    win_en = 0;

    // Mode switch mid-pattern on ch0
    reset_pulse(0);
    run_to(80, 8'h03);
    run_to(81, 8'h02);
    check("sw_phase_a", led[0], 1'b1);
    run_to(96, 8'h02);
    check("sw_phase_b", led[0], 1'b1);
    run_to(97, 8'h02);
    check("sw_phase_c", led[0], 1'b0);
    run_to(112, 8'h02);
    win_en = 1; win_ch = 0;
    run_to(121, 8'h03);
    win_en = 0;

    // Channel independence
    reset_pulse(0);
    win_en = 1; win_ch = 3;
    run_to(2, 8'hE4);
    check("ind_ch2_a", led[2], 1'b0);
    run_to(17, 8'hE4);
    check("ind_ch2_b", led[2], 1'b1);
    run_to(33, 8'hE4);
    check("ind_ch2_c", led[2], 1'b0);
    run_to(300, 8'hE4);
    check("ind_ch01", led[1:0], 2'b10);
    win_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
